pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Central stall/flush sequencer for the five-stage pipeline. It watches ID-stage operands, the load in EX, the data-memory handshake in MEM, branch resolution in EX and `jr` resolution in WB. From these it drives the enable and flush strobes of the PC, IF_ID, ID_EX, EX_MEM and MEM_WB registers. A small FSM handles multi-cycle data-memory waits and a fatal memory-timeout halt.

## Interface
- `MEM_TIMEOUT`, default 16: maximum consecutive cycles spent in MEM_WAIT before halting; 0 disables the timeout.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `id_rs`, `id_rt`  in  5 each  source register numbers of the instruction in ID.
- `id_uses_rs`, `id_uses_rt`  in  1 each  the ID instruction actually reads that operand.
- `ex_mem_read`  in  1  the instruction in EX is a load.
- `ex_regd`  in  5  destination register of the EX instruction.
- `branch_taken_ex`  in  1  branch resolved taken in EX.
- `mem_req`  in  1  the MEM-stage instruction accesses data memory.
- `dmem_ack`  in  1  data memory has completed the current access.
- `jr_wb`  in  1  a `jr` is in WB (the MEM_WB `jr` bit).
- `pc_en`, `ifid_en`, `idex_en`, `exmem_en`, `memwb_en`  out  1 each  register load enables.
- `ifid_flush`, `idex_flush`, `exmem_flush`, `memwb_flush`  out  1 each  load a bubble (all-zero control) on this edge; a flush overrides the matching enable.
- `pc_sel_jr`  out  1  the PC loads the `jr` target this cycle.
- `mem_kill`  out  1  cancel the MEM-stage data-memory request.
- `mem_err`  out  1  sticky memory-timeout flag.
- `stall_cycles`  out  32  present only with PERF_CNT_EN.
- `flush_events`  out  16  present only with PERF_CNT_EN.

## Operation
- FSM states: RUN, MEM_WAIT, HALT. Outputs are Mealy: a function of the current state and the current inputs.
- Default output in RUN: all `*_en`=1; all flushes, `pc_sel_jr` and `mem_kill`=0.
- RUN conditions are evaluated in priority order; only the highest-priority true condition acts.
  1. `jr_wb`: `pc_sel_jr`=1; `ifid_flush`, `idex_flush`, `exmem_flush`, `memwb_flush`=1; `mem_kill`=1. Stay in RUN.
  2. `mem_req & !dmem_ack`: `pc_en`, `ifid_en`, `idex_en`, `exmem_en`=0; `memwb_flush`=1. Next state MEM_WAIT; `wait_cnt` becomes 1.
  3. `branch_taken_ex`: `ifid_flush`=1 and `idex_flush`=1.
  4. Load-use: `ex_mem_read`, `ex_regd`≠0, and (`id_uses_rs` & `id_rs`==`ex_regd` | `id_uses_rt` & `id_rt`==`ex_regd`). Response: `pc_en`=0, `ifid_en`=0, `idex_flush`=1. One bubble only; the next cycle re-evaluates.
- MEM_WAIT behaves as condition 2 every cycle.
  - On `dmem_ack`=1, this cycle uses RUN default outputs and the next state is RUN.
  - `jr_wb` cannot be true here because WB holds a bubble.
  - `wait_cnt` increments each cycle without ack. If `MEM_TIMEOUT`≠0 and `wait_cnt`==`MEM_TIMEOUT` with no ack: `mem_err`←1, next state HALT.
- HALT: all enables 0, all flushes 0, `mem_kill`=1. Only `rst` exits.
- Stalled branches and load-use hazards stay held in their registers and are re-evaluated after MEM_WAIT exits.

## Timing
- Decisions are combinational and take effect on the same rising edge; no added latency.
- Load-use costs exactly 1 bubble. A taken branch costs 2 flushed slots. `jr` costs 4.
- A memory access with ack in cycle N (counting the first request cycle as 1) stalls for N−1 cycles.
- `wait_cnt` width is clog2(`MEM_TIMEOUT`+1), minimum 1. It clears on entry to RUN.
- While `rst`=1: all enables and flushes are 0, and `pc_sel_jr`, `mem_kill`, `mem_err`=0.
- After reset: state RUN, `wait_cnt`=0, `mem_err`=0, counters 0. A reset asserted mid-MEM_WAIT or in HALT returns to RUN on the next edge.

## Configuration
- `PIPE_HAZARD_PERF_CNT_EN` defined: adds the `stall_cycles` and `flush_events` ports.
  - `stall_cycles` increments on every cycle with `pc_en`=0 in RUN or MEM_WAIT.
  - `flush_events` increments on every cycle in which any flush is 1.
  - Both saturate at all-ones and clear on `rst`.
- `PIPE_HAZARD_PERF_CNT_EN` undefined: neither port nor counter exists; all other behaviour is identical.

## Test plan
- Load-use: `ex_mem_read`=1, `ex_regd`=5, `id_rs`=5, `id_uses_rs`=1 → for 1 cycle `pc_en`=0, `ifid_en`=0, `idex_flush`=1; the next cycle (load now in MEM) returns to RUN defaults. Repeat with `ex_regd`=0 → no stall.
- Memory wait: `mem_req`=1, `dmem_ack` low for 3 cycles then high → 3 cycles with stall enables 0 and `memwb_flush`=1, then 1 cycle of defaults; `mem_err`=0.
- Timeout: `MEM_TIMEOUT`=4, `dmem_ack` held 0 → HALT entered, `mem_err`=1 and sticky. `dmem_ack`=1 then has no effect. `rst` → RUN, `mem_err`=0.
- Priority: `jr_wb`=1, `mem_req`=1, `dmem_ack`=0, `branch_taken_ex`=1 in the same cycle → jr response only (4 flushes, `pc_sel_jr`=1, `mem_kill`=1), next state RUN.
- Branch during wait: `branch_taken_ex`=1 while in MEM_WAIT → no flush until the ack cycle; the flush occurs on the first RUN cycle after ack.
- With PERF_CNT_EN: the load-use case, then the 3-cycle memory wait → `stall_cycles`=4, `flush_events`=4.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - hazard observation inputs and pipeline-register control strobes
interface pipe_hazard_ctrl_if;
  // ID-stage operand usage
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_uses_rs;
  logic       id_uses_rt;
  // EX-stage load and branch resolution
  logic       ex_mem_read;
  logic [4:0] ex_regd;
  logic       branch_taken_ex;
  // MEM-stage data-memory handshake
  logic       mem_req;
  logic       dmem_ack;
  // WB-stage jr resolution
  logic       jr_wb;
  // register load enables
  logic       pc_en;
  logic       ifid_en;
  logic       idex_en;
  logic       exmem_en;
  logic       memwb_en;
  // bubble injection, each overrides the matching enable
  logic       ifid_flush;
  logic       idex_flush;
  logic       exmem_flush;
  logic       memwb_flush;
  // PC source, memory cancel and fatal status
  logic       pc_sel_jr;
  logic       mem_kill;
  logic       mem_err;

  // pipeline side: reports hazards, consumes strobes
  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt,
    output ex_mem_read, ex_regd, branch_taken_ex,
    output mem_req, dmem_ack, jr_wb,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
    input  ifid_flush, idex_flush, exmem_flush, memwb_flush,
    input  pc_sel_jr, mem_kill, mem_err
  );

  // controller side: observes hazards, drives strobes
  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt,
    input  ex_mem_read, ex_regd, branch_taken_ex,
    input  mem_req, dmem_ack, jr_wb,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
    output ifid_flush, idex_flush, exmem_flush, memwb_flush,
    output pc_sel_jr, mem_kill, mem_err
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - five-stage stall/flush sequencer; optional counters under PIPE_HAZARD_PERF_CNT_EN
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst,
  pipe_hazard_ctrl_if.slave   hz
`ifdef PIPE_HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]         stall_cycles,
  output logic [15:0]         flush_events
`endif
);

  // wait counter must hold MEM_TIMEOUT itself; a zero timeout still needs one bit
  localparam int CNT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
  localparam bit               TIMEOUT_ON  = (MEM_TIMEOUT != 0);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_HALT     = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic             mem_err_q;

  logic load_use;
  logic rs_hit;
  logic rt_hit;
  logic mem_stall_req;
  logic timeout_hit;

  logic pc_en;
  logic ifid_en;
  logic idex_en;
  logic exmem_en;
  logic memwb_en;
  logic ifid_flush;
  logic idex_flush;
  logic exmem_flush;
  logic memwb_flush;
  logic pc_sel_jr;
  logic mem_kill;

  // hazard detection on the raw stage inputs
  always_comb begin
    rs_hit        = hz.id_uses_rs && (hz.id_rs == hz.ex_regd);
    rt_hit        = hz.id_uses_rt && (hz.id_rt == hz.ex_regd);
    // r0 is hardwired, so a load targeting it can never create a dependency
    load_use      = hz.ex_mem_read && (hz.ex_regd != 5'd0) && (rs_hit || rt_hit);
    mem_stall_req = hz.mem_req && !hz.dmem_ack;
    timeout_hit   = TIMEOUT_ON && (wait_cnt == TIMEOUT_VAL);
  end

  // Mealy strobe generation from current state and current hazards
  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    memwb_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    memwb_flush = 1'b0;
    pc_sel_jr   = 1'b0;
    mem_kill    = 1'b0;
    if (rst) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      memwb_en = 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (hz.jr_wb) begin
            // jr squashes every younger instruction, including a pending memory access
            pc_sel_jr   = 1'b1;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            memwb_flush = 1'b1;
            mem_kill    = 1'b1;
          end else if (mem_stall_req) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            memwb_flush = 1'b1;
          end else if (hz.branch_taken_ex) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
          end else if (load_use) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
          end
        end
        ST_MEM_WAIT: begin
          // the ack cycle releases the pipeline with plain defaults; held hazards re-evaluate next cycle
          if (!hz.dmem_ack) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            memwb_flush = 1'b1;
          end
        end
        ST_HALT: begin
          pc_en    = 1'b0;
          ifid_en  = 1'b0;
          idex_en  = 1'b0;
          exmem_en = 1'b0;
          memwb_en = 1'b0;
          mem_kill = 1'b1;
        end
        default: begin
          pc_en    = 1'b0;
          ifid_en  = 1'b0;
          idex_en  = 1'b0;
          exmem_en = 1'b0;
          memwb_en = 1'b0;
          mem_kill = 1'b1;
        end
      endcase
    end
  end

  // sequencer state, memory-wait counter and sticky timeout flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_RUN;
      wait_cnt  <= '0;
      mem_err_q <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (!hz.jr_wb && mem_stall_req) begin
            state    <= ST_MEM_WAIT;
            wait_cnt <= CNT_ONE;
          end else begin
            wait_cnt <= '0;
          end
        end
        ST_MEM_WAIT: begin
          if (hz.dmem_ack) begin
            state    <= ST_RUN;
            wait_cnt <= '0;
          end else if (timeout_hit) begin
            state     <= ST_HALT;
            mem_err_q <= 1'b1;
          end else if (wait_cnt != CNT_MAX) begin
            // saturation only matters when the timeout is disabled
            wait_cnt <= wait_cnt + CNT_ONE;
          end
        end
        ST_HALT: begin
          state <= ST_HALT;
        end
        default: begin
          state <= ST_HALT;
        end
      endcase
    end
  end

  // drive the interface; mem_err is masked while reset is held
  always_comb begin
    hz.pc_en       = pc_en;
    hz.ifid_en     = ifid_en;
    hz.idex_en     = idex_en;
    hz.exmem_en    = exmem_en;
    hz.memwb_en    = memwb_en;
    hz.ifid_flush  = ifid_flush;
    hz.idex_flush  = idex_flush;
    hz.exmem_flush = exmem_flush;
    hz.memwb_flush = memwb_flush;
    hz.pc_sel_jr   = pc_sel_jr;
    hz.mem_kill    = mem_kill;
    hz.mem_err     = mem_err_q && !rst;
  end

`ifdef PIPE_HAZARD_PERF_CNT_EN
  logic any_flush;
  logic stalling;

  // classify the current cycle for the performance counters
  always_comb begin
    any_flush = ifid_flush || idex_flush || exmem_flush || memwb_flush;
    stalling  = !pc_en && ((state == ST_RUN) || (state == ST_MEM_WAIT));
  end

  // saturating stall-cycle and flush-event counters
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (stalling && (stall_cycles != 32'hFFFF_FFFF)) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
      if (any_flush && (flush_events != 16'hFFFF)) begin
        flush_events <= flush_events + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

  // packed strobe order: pc,ifid,idex,exmem,memwb en | ifid,idex,exmem,memwb flush | pc_sel_jr, mem_kill, mem_err
  localparam logic [11:0] ZERO  = 12'b00000_0000_000;
  localparam logic [11:0] DEF   = 12'b11111_0000_000;
  localparam logic [11:0] STALL = 12'b00001_0001_000;
  localparam logic [11:0] LU    = 12'b00111_0100_000;
  localparam logic [11:0] BR    = 12'b11111_1100_000;
  localparam logic [11:0] JR    = 12'b11111_1111_110;
  localparam logic [11:0] HALT  = 12'b00000_0000_011;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  logic [11:0] outs;

  pipe_hazard_ctrl_if hz();

`ifdef PIPE_HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles;
  logic [15:0] flush_events;
`endif

  pipe_hazard_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
`ifdef PIPE_HAZARD_PERF_CNT_EN
    ,
    .stall_cycles (stall_cycles),
    .flush_events (flush_events)
`endif
  );

  assign outs = {hz.pc_en, hz.ifid_en, hz.idex_en, hz.exmem_en, hz.memwb_en,
                 hz.ifid_flush, hz.idex_flush, hz.exmem_flush, hz.memwb_flush,
                 hz.pc_sel_jr, hz.mem_kill, hz.mem_err};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    hz.id_rs           = 5'd0;
    hz.id_rt           = 5'd0;
    hz.id_uses_rs      = 1'b0;
    hz.id_uses_rt      = 1'b0;
    hz.ex_mem_read     = 1'b0;
    hz.ex_regd         = 5'd0;
    hz.branch_taken_ex = 1'b0;
    hz.mem_req         = 1'b0;
    hz.dmem_ack        = 1'b0;
    hz.jr_wb           = 1'b0;
  endtask

  // sample strobes mid-cycle, then advance to just after the next rising edge
  task automatic expect_cycle(input string tag, input logic [11:0] exp);
    @(negedge clk);
    check(tag, {20'd0, outs}, {20'd0, exp});
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    expect_cycle("reset_outputs", ZERO);
    rst = 1'b0;
    expect_cycle("idle_defaults", DEF);

    // load-use on rs: one bubble, then the load has moved to MEM
    hz.ex_mem_read = 1'b1; hz.ex_regd = 5'd5; hz.id_rs = 5'd5; hz.id_uses_rs = 1'b1;
    expect_cycle("load_use_rs", LU);
    clear_inputs();
    expect_cycle("load_use_recover", DEF);

    // three cycles without ack, ack on the fourth
    hz.mem_req = 1'b1;
    for (int i = 0; i < 3; i++) expect_cycle($sformatf("mem_wait_%0d", i), STALL);
    hz.dmem_ack = 1'b1;
    expect_cycle("mem_ack_cycle", DEF);
`ifdef PIPE_HAZARD_PERF_CNT_EN
    check("perf_stall_cycles", stall_cycles, 32'd4);
    check("perf_flush_events", {16'd0, flush_events}, 32'd4);
`endif
    clear_inputs();
    expect_cycle("after_mem_run", DEF);

    // r0 destination never stalls
    hz.ex_mem_read = 1'b1; hz.ex_regd = 5'd0; hz.id_rs = 5'd0; hz.id_uses_rs = 1'b1;
    expect_cycle("load_use_r0", DEF);
    // rt dependency
    hz.ex_regd = 5'd7; hz.id_rt = 5'd7; hz.id_uses_rt = 1'b1; hz.id_uses_rs = 1'b0;
    expect_cycle("load_use_rt", LU);
    // matching register but operand not read
    hz.id_uses_rt = 1'b0;
    expect_cycle("load_use_unused", DEF);
    clear_inputs();

    // jr wins over memory stall and branch
    hz.jr_wb = 1'b1; hz.mem_req = 1'b1; hz.branch_taken_ex = 1'b1;
    expect_cycle("priority_jr", JR);
    clear_inputs();
    expect_cycle("priority_jr_next_run", DEF);

    hz.branch_taken_ex = 1'b1;
    expect_cycle("branch_taken", BR);
    hz.ex_mem_read = 1'b1; hz.ex_regd = 5'd3; hz.id_rs = 5'd3; hz.id_uses_rs = 1'b1;
    expect_cycle("branch_over_load_use", BR);
    clear_inputs();

    // branch held during a memory wait flushes only after ack
    hz.mem_req = 1'b1; hz.branch_taken_ex = 1'b1;
    expect_cycle("wait_over_branch", STALL);
    expect_cycle("branch_in_wait", STALL);
    hz.dmem_ack = 1'b1;
    expect_cycle("branch_ack_cycle", DEF);
    hz.mem_req = 1'b0; hz.dmem_ack = 1'b0;
    expect_cycle("branch_after_wait", BR);
    clear_inputs();

    // reset in the middle of a wait returns to RUN
    hz.mem_req = 1'b1;
    expect_cycle("wait_before_reset", STALL);
    rst = 1'b1;
    expect_cycle("reset_mid_wait", ZERO);
    rst = 1'b0;
    hz.mem_req = 1'b0;
    expect_cycle("run_after_wait_reset", DEF);

    // timeout of 4: request cycle plus wait counts 1..4, then HALT
    hz.mem_req = 1'b1;
    for (int i = 0; i < 5; i++) expect_cycle($sformatf("timeout_stall_%0d", i), STALL);
    expect_cycle("halt_entered", HALT);
    expect_cycle("halt_held", HALT);
    hz.dmem_ack = 1'b1;
    expect_cycle("halt_ignores_ack", HALT);
    clear_inputs();
    hz.jr_wb = 1'b1;
    expect_cycle("halt_ignores_jr", HALT);
    clear_inputs();
    rst = 1'b1;
    expect_cycle("reset_in_halt", ZERO);
    rst = 1'b0;
    expect_cycle("run_after_halt", DEF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
